// File: rtl/ysyx_22050039_pkg.sv
// ysyx_22050039_pkg: shared fetch-side types and constants (responder FSM states, PC reset base, instruction width).
package ysyx_22050039_pkg;

    localparam int ILEN = 32;
    localparam logic [63:0] DEFAULT_BASE_ADDR = 64'h8000_0000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } imem_state_e;

endpackage

// File: rtl/ysyx_22050039_imem_array.sv
// ysyx_22050039_imem_array: MEM_WORDS x ILEN word store, one sync write (load) port, one sync read port.
// The read samples the pre-edge contents, so a same-index write at the same edge is not seen.
module ysyx_22050039_imem_array
    import ysyx_22050039_pkg::*;
#(
    parameter int MEM_WORDS = 4096,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   widx,
    input  logic [ILEN-1:0] wdata,
    input  logic            re,
    input  logic [AW-1:0]   ridx,
    output logic [ILEN-1:0] rdata
);

    logic [ILEN-1:0] mem [MEM_WORDS];
    logic [ILEN-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[widx] <= wdata;
        if (re) rdata_q <= mem[ridx];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ysyx_22050039_imem_resp.sv
// ysyx_22050039_imem_resp: IFU fetch responder; one request at a time, fixed LATENCY, word or error response.
// Define YSYX_22050039_IMEM_TRACE_EN to print each accepted request and each response handshake.
module ysyx_22050039_imem_resp
    import ysyx_22050039_pkg::*;
#(
    parameter int              XLEN      = 64,
    parameter int              MEM_WORDS = 4096,
    parameter logic [XLEN-1:0] BASE_ADDR = XLEN'(DEFAULT_BASE_ADDR),
    parameter int              LATENCY   = 2,
    parameter int              AW        = $clog2(MEM_WORDS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [ILEN-1:0] resp_inst,
    output logic            resp_err,
    input  logic            ld_en,
    input  logic [AW-1:0]   ld_idx,
    input  logic [ILEN-1:0] ld_data
);

    // One extra bit keeps the upper bound from wrapping when BASE_ADDR sits near the top of the space.
    localparam logic [XLEN:0] LIMIT = {1'b0, BASE_ADDR} + (XLEN+1)'(4 * MEM_WORDS);

    imem_state_e     state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            err_q, err_d;
    logic            rd_en, addr_err;
    logic [AW-1:0]   rd_idx;
    logic [ILEN-1:0] rd_data;

    assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q < BASE_ADDR) || ({1'b0, addr_q} >= LIMIT);
    assign rd_idx   = AW'((addr_q - BASE_ADDR) >> 2);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        err_d      = err_q;
        rd_en      = 1'b0;
        req_ready  = rst && (state_q == IDLE);
        resp_valid = (state_q == RESP);
        case (state_q)
            IDLE: if (req_valid && req_ready) begin
                addr_d  = req_addr;
                cnt_d   = 4'(LATENCY - 1);
                state_d = WAIT;
            end
            WAIT: if (cnt_q == 4'd0) begin
                err_d   = addr_err;
                rd_en   = rst;
                state_d = RESP;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            RESP: if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    // The array output register holds the word; gating keeps it zero outside RESP and on errors.
    assign resp_inst = (resp_valid && !err_q) ? rd_data : '0;
    assign resp_err  = err_q;

    ysyx_22050039_imem_array #(
        .MEM_WORDS(MEM_WORDS),
        .AW       (AW)
    ) u_array (
        .clk  (clk),
        .we   (ld_en),
        .widx (ld_idx),
        .wdata(ld_data),
        .re   (rd_en),
        .ridx (rd_idx),
        .rdata(rd_data)
    );

`ifdef YSYX_22050039_IMEM_TRACE_EN
    always_ff @(posedge clk) begin
        if (req_valid && req_ready) $display("IMEM req addr=0x%x", req_addr);
        if (rst && resp_valid && resp_ready) $display("IMEM resp inst=0x%x err=%d", resp_inst, resp_err);
    end
`endif

endmodule
